// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the core and a debug/loader requester.
// One access at a time: IDLE -> ISSUE -> (WAIT) -> ACK, with registered outputs throughout.
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy,
  output logic [CW-1:0] conflict_cnt
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

  localparam logic [2:0] LatInit = 3'(MEM_LAT);

  state_e        r_state;
  logic          r_sel_d;
  logic          r_last_d;
  logic [2:0]    r_lat;
  logic          r_c_ack;
  logic          r_d_ack;
  logic [DW-1:0] r_c_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_m_en;
  logic          r_m_we;
  logic [AW-1:0] r_m_addr;
  logic [DW-1:0] r_m_wdata;
  logic          r_busy;
  logic [CW-1:0] r_conflict_cnt;

  logic w_any;
  logic w_both;
  logic w_pick_d;
  logic w_sat;

  // On a tie the requester that was not granted last wins.
  assign w_any    = c_req | d_req;
  assign w_both   = c_req & d_req;
  assign w_pick_d = d_req & (~c_req | ~r_last_d);
  assign w_sat    = &r_conflict_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= StIdle;
      r_sel_d        <= 1'b0;
      r_last_d       <= 1'b1;
      r_lat          <= 3'd0;
      r_c_ack        <= 1'b0;
      r_d_ack        <= 1'b0;
      r_c_rdata      <= '0;
      r_d_rdata      <= '0;
      r_m_en         <= 1'b0;
      r_m_we         <= 1'b0;
      r_m_addr       <= '0;
      r_m_wdata      <= '0;
      r_busy         <= 1'b0;
      r_conflict_cnt <= '0;
    end else begin
      r_c_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_m_en    <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      case (r_state)
        StIdle: begin
          if (w_both && !w_sat) begin
            r_conflict_cnt <= r_conflict_cnt + CW'(1);
          end
          if (w_any) begin
            // The winner's command is latched straight into the port registers for ISSUE.
            r_sel_d   <= w_pick_d;
            r_last_d  <= w_pick_d;
            r_m_en    <= 1'b1;
            r_m_we    <= w_pick_d ? d_we : c_we;
            r_m_addr  <= w_pick_d ? d_addr : c_addr;
            r_m_wdata <= w_pick_d ? d_wdata : c_wdata;
            r_busy    <= 1'b1;
            r_state   <= StIssue;
          end
        end
        StIssue: begin
          if (r_m_we) begin
            r_c_ack <= ~r_sel_d;
            r_d_ack <= r_sel_d;
            r_state <= StAck;
          end else begin
            r_lat   <= LatInit;
            r_state <= StWait;
          end
        end
        StWait: begin
          r_lat <= r_lat - 3'd1;
          // r_lat reaches 1 on the cycle the memory presents read data.
          if (r_lat == 3'd1) begin
            if (r_sel_d) begin
              r_d_rdata <= m_rdata;
            end else begin
              r_c_rdata <= m_rdata;
            end
            r_c_ack <= ~r_sel_d;
            r_d_ack <= r_sel_d;
            r_state <= StAck;
          end
        end
        StAck: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign c_ack        = r_c_ack;
  assign d_ack        = r_d_ack;
  assign c_rdata      = r_c_rdata;
  assign d_rdata      = r_d_rdata;
  assign m_en         = r_m_en;
  assign m_we         = r_m_we;
  assign m_addr       = r_m_addr;
  assign m_wdata      = r_m_wdata;
  assign busy         = r_busy;
  assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers queue expected transactions, a monitor
// checks port accesses, grants, acks and read data against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned ML  = 3;
  localparam int unsigned CW  = 3;
  localparam int          MAXC = (1 << CW) - 1;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic          clk;
  logic          reset;
  logic          c_req, c_we, c_ack;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic          d_req, d_we, d_ack;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          busy;
  logic [CW-1:0] conflict_cnt;

  int   n_chk  = 0;
  int   n_pass = 0;
  txn_t q_c[$];
  txn_t q_d[$];
  bit   grant_log[$];
  logic [DW-1:0] gold [64];

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(ML), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy), .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int unsigned a);
    if (a == 32'h10) return 32'hDEAD_BEEF;
    return 32'hA5A5_0000 ^ (a * 32'h0101_0193);
  endfunction

  // Memory with MEM_LAT-cycle read pipeline; non-read slots carry random garbage.
  logic [DW-1:0] mem [64];
  logic [63:0]   written = '0;
  logic [DW-1:0] rd_pipe [ML];
  logic [5:0]    ma;
  assign ma      = m_addr[5:0];
  assign m_rdata = rd_pipe[ML-1];

  always @(posedge clk) begin
    if (m_en && m_we) begin
      mem[ma]     <= m_wdata;
      written[ma] <= 1'b1;
    end
    rd_pipe[0] <= (m_en && !m_we) ? (written[ma] ? mem[ma] : init_val(32'(ma))) : $urandom();
    for (int i = 1; i < int'(ML); i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    int cyc = 0;
    int issue_cyc = 0;
    int conf = 0;
    bit in_flight = 0;
    bit cur_d = 0;
    bit last_d = 1;
    bit p_c = 0;
    bit p_d = 0;
    bit w;
    bit exp_busy;
    txn_t cur;
    logic [DW-1:0] exp_cr = '0;
    logic [DW-1:0] exp_dr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        chk("rst_ctl", 64'({c_ack, d_ack, m_en, m_we, busy, conflict_cnt}), 64'(0));
        chk("rst_rdata", 64'({c_rdata, d_rdata}), 64'(0));
        chk("rst_mport", 64'({m_addr, m_wdata}), 64'(0));
        in_flight = 0; last_d = 1; conf = 0; exp_cr = '0; exp_dr = '0;
        q_c.delete(); q_d.delete();
        p_c = c_req; p_d = d_req;
        continue;
      end
      exp_busy = in_flight || m_en;
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("conflict_cnt", 64'(conflict_cnt), 64'(conf));
      if (!in_flight && !m_en && c_req && d_req && conf < MAXC) conf++;
      if (m_en) begin
        chk("issue_overlap", 64'(in_flight), 64'(0));
        chk("grant_has_req", 64'(p_c | p_d), 64'(1));
        w = (p_c && p_d) ? !last_d : p_d;
        last_d = w;
        cur_d = w;
        grant_log.push_back(w);
        chk("grant_pending", 64'(w ? q_d.size() : q_c.size()), 64'(1));
        if (w && q_d.size() > 0) cur = q_d.pop_front();
        else if (!w && q_c.size() > 0) cur = q_c.pop_front();
        chk("m_we", 64'(m_we), 64'(cur.we));
        chk("m_addr", 64'(m_addr), 64'(cur.addr));
        chk("m_wdata", 64'(m_wdata), 64'(cur.wdata));
        in_flight = 1;
        issue_cyc = cyc;
      end else begin
        chk("m_idle_we", 64'(m_we), 64'(0));
        chk("m_idle_bus", 64'({m_addr, m_wdata}), 64'(0));
      end
      chk("ack_exclusive", 64'(c_ack & d_ack), 64'(0));
      if (c_ack || d_ack) begin
        chk("ack_expected", 64'(in_flight), 64'(1));
        if (in_flight) begin
          chk("ack_target", 64'(d_ack), 64'(cur_d));
          chk("ack_latency", 64'(cyc - issue_cyc), 64'(cur.we ? 1 : 1 + ML));
          if (cur.we) gold[cur.addr[5:0]] = cur.wdata;
          else if (cur_d) exp_dr = gold[cur.addr[5:0]];
          else exp_cr = gold[cur.addr[5:0]];
          in_flight = 0;
        end
      end else if (in_flight && (cyc - issue_cyc) > int'(1 + ML)) begin
        chk("ack_timeout", 64'(0), 64'(1));
        in_flight = 0;
      end
      chk("c_rdata", 64'(c_rdata), 64'(exp_cr));
      chk("d_rdata", 64'(d_rdata), 64'(exp_dr));
      p_c = c_req;
      p_d = d_req;
    end
  endtask

  task automatic raise(input bit sel, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wd;
    if (sel) begin
      d_we = we; d_addr = addr; d_wdata = wd; d_req = 1'b1; q_d.push_back(t);
    end else begin
      c_we = we; c_addr = addr; c_wdata = wd; c_req = 1'b1; q_c.push_back(t);
    end
  endtask

  task automatic wait_ack(input bit sel, output int lat);
    bit got = 0;
    lat = 0;
    while (!got && lat < 64) begin
      tick();
      lat++;
      got = sel ? d_ack : c_ack;
    end
    if (!got) chk(sel ? "d_ack_wait" : "c_ack_wait", 64'(0), 64'(1));
    if (sel) d_req = 1'b0;
    else c_req = 1'b0;
  endtask

  task automatic txn(input bit sel, input logic we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wd, output int lat);
    raise(sel, we, addr, wd);
    wait_ack(sel, lat);
    tick();
    tick();
  endtask

  initial begin
    int lat_c, lat_d, lat;
    int log_start;
    for (int i = 0; i < 64; i++) gold[i] = init_val(32'(i));
    reset = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    fork
      monitor();
    join_none

    // Reset held with a pending core request, then released with both requesting.
    repeat (3) tick();
    reset = 1'b1;
    fork
      begin
        txn(1'b0, 1'b0, 32'h10, 32'h0, lat_c);
        chk("core_read_latency", 64'(lat_c), 64'(2 + ML));
        chk("core_read_data", 64'(c_rdata), 64'(32'hDEAD_BEEF));
      end
      txn(1'b1, 1'b1, 32'h30, 32'hCAFE_0001, lat_d);
    join
    chk("first_grant_core", 64'(grant_log[0]), 64'(0));

    // Debug write then core read-back of the same word.
    txn(1'b1, 1'b1, 32'h20, 32'h1234_5678, lat);
    chk("dbg_write_latency", 64'(lat), 64'(2));
    txn(1'b0, 1'b0, 32'h20, 32'h0, lat);
    chk("readback_data", 64'(c_rdata), 64'(32'h1234_5678));
    chk("dbg_rdata_untouched", 64'(d_rdata), 64'(0));

    // Core read: drop request and scramble inputs during WAIT.
    raise(1'b0, 1'b0, 32'h05, 32'h0);
    tick();
    tick();
    c_req = 1'b0; c_addr = 32'h30; c_we = 1'b1; c_wdata = 32'hBAD0_BAD0;
    wait_ack(1'b0, lat);
    chk("dropped_req_latency", 64'(lat + 2), 64'(2 + ML));
    chk("dropped_req_data", 64'(c_rdata), 64'(gold[5]));
    tick();
    tick();

    // Reset during WAIT discards the access; reissue completes normally.
    raise(1'b1, 1'b0, 32'h07, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    d_req = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    repeat (3) begin
      tick();
      chk("no_ack_after_reset", 64'({c_ack, d_ack, busy}), 64'(0));
    end
    txn(1'b1, 1'b0, 32'h07, 32'h0, lat);
    chk("reissue_latency", 64'(lat), 64'(2 + ML));
    chk("reissue_data", 64'(d_rdata), 64'(gold[7]));

    // Repeated simultaneous requests: strict alternation and counter saturation.
    log_start = grant_log.size();
    for (int i = 0; i < 10; i++) begin
      fork
        txn(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom(), lat_c);
        txn(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom(), lat_d);
      join
    end
    for (int i = log_start + 1; i < grant_log.size(); i++)
      chk("grant_alternates", 64'(grant_log[i] != grant_log[i-1]), 64'(1));
    chk("conflict_saturated", 64'(conflict_cnt), 64'(MAXC));

    // Randomized independent traffic from both requesters over a shared address range.
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        txn(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom(), lat_c);
      end
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        txn(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom(), lat_d);
      end
    join

    repeat (5) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the multi-cycle core's single unified instruction/data memory port between two requesters: the core FSM (fetch, load, store) and a debug/program-loader port. A round-robin FSM grants one requester at a time, issues a single memory access, waits the memory read latency and returns a one-cycle acknowledge with registered read data. The core holds its current state, with IRWrite/RegWrite gated, until it sees its acknowledge.

Parameters:
AW, 32, address width
DW, 32, data width
MEM_LAT, 1, memory read latency in cycles; legal range 1..4
CW, 16, width of conflict statistics counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
c_req  in  1  core request; held until c_ack
c_we  in  1  core write enable (1 = store)
c_addr  in  AW  core address
c_wdata  in  DW  core write data
c_ack  out  1  core transaction complete, one-cycle pulse
c_rdata  out  DW  core read data; valid with c_ack, held until next core read ack
d_req  in  1  debug request; held until d_ack
d_we  in  1  debug write enable
d_addr  in  AW  debug address
d_wdata  in  DW  debug write data
d_ack  out  1  debug transaction complete, one-cycle pulse
d_rdata  out  DW  debug read data; same rules as c_rdata
m_en  out  1  memory access strobe
m_we  out  1  memory write enable
m_addr  out  AW  memory address
m_wdata  out  DW  memory write data
m_rdata  in  DW  memory read data; valid MEM_LAT cycles after the m_en cycle
busy  out  1  high in any state other than IDLE
conflict_cnt  out  CW  saturating count of IDLE cycles where c_req and d_req are both high

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; all outputs 0, including rdata registers and conflict_cnt.
  - last-grant pointer = debug, so the core wins the first tie.
  - An in-flight transaction is discarded: no ack is issued and the requester must reissue.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If exactly one request is pending, grant it.
  - If both are pending, grant the requester that is not the last-grant pointer.
  - On grant: latch we/addr/wdata of the winner, update the last-grant pointer, go to ISSUE.
- ISSUE (1 cycle):
  - m_en=1; m_we/m_addr/m_wdata driven from latched values. m_en, m_we, m_addr and m_wdata are 0 in every other state.
  - Write: go to ACK.
  - Read: go to WAIT with the latency counter loaded with MEM_LAT.
- WAIT:
  - Counter decrements each cycle.
  - On the cycle m_rdata is valid (the MEM_LAT-th cycle after ISSUE), capture m_rdata into the granted requester's rdata register, then go to ACK.
  - The other requester's rdata register is unchanged.
- ACK (1 cycle): assert the granted requester's ack only, then go to IDLE. Acks are never asserted together.
- Latency, with the request first seen in IDLE at cycle 0:
  - Write: ISSUE at cycle 1, ack at cycle 2.
  - Read: ISSUE at cycle 1, data captured at end of cycle 1+MEM_LAT, ack at cycle 2+MEM_LAT.
- Handshake:
  - Requests are sampled only in IDLE. Requester inputs are ignored after grant; changes to addr/wdata/we mid-transaction have no effect.
  - A request dropped after grant still completes and is still acked.
  - A requester must deassert req in the cycle after ack. A req still high in the IDLE cycle after ack is a new request.
  - Minimum spacing between ack and the next ISSUE is one IDLE cycle.
- Fairness: with both requesting continuously, grants strictly alternate; no starvation beyond one transaction.
- conflict_cnt:
  - Increments by 1 in each IDLE cycle with c_req && d_req.
  - Saturates at 2^CW-1; no wrap.
  - Cleared only by reset.

Test Plan:
- Reset/idle: hold reset=0 with c_req=1 → all outputs 0. Release reset → grant to core; m_en=1 at cycle 1 with m_addr=c_addr; busy=1 from cycle 1 until the cycle after ack.
- Core read, MEM_LAT=1: c_addr=0x10, memory[0x10]=0xDEADBEEF → m_en at cycle 1, c_ack at cycle 3 with c_rdata=0xDEADBEEF; d_ack stays 0.
- Debug write: d_we=1, d_addr=0x20, d_wdata=0x12345678 → m_en=m_we=1 at cycle 1 with m_wdata=0x12345678; d_ack at cycle 2; a follow-up core read of 0x20 returns 0x12345678.
- Simultaneous requests, both held for 4 transactions → grant order core, debug, core, debug; conflict_cnt increments once per IDLE cycle with both requests high; d_rdata never changes on a core ack.
- MEM_LAT=3 rebuild, core read → c_ack at cycle 5. Drop c_req and change c_addr during WAIT → ack still issued and data comes from the originally latched address.
- Reset mid-transaction: assert reset during WAIT → no ack is issued and state returns to IDLE. Reissued request completes normally.
